// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and constants for the sequential CLA adder
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/cla_nibble.sv
// rtl/cla_nibble.sv - combinational 4-bit carry-look-ahead adder slice
module cla_nibble
    import cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and cin, no ripple path.
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[NIBBLE_W-1:0];
    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - WIDTH-bit add/sub sequenced over one CLA nibble slice
module cla_seq_adder_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W+1:0]  base;
    logic              carry_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic              slice_cout;
    logic              last;

    assign base    = {idx, 2'b00};
    assign slice_a = a_r[base +: NIBBLE_W];
    assign slice_b = b_r[base +: NIBBLE_W];
    assign last    = (idx == IDX_W'(NIBBLES - 1));

    cla_nibble u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_r),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state == RUN) || (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is folded in at capture: b is inverted and the +1 enters as carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub | cin;
                        idx     <= '0;
                        sum     <= '0;
                    end
                end
                RUN: begin
                    sum[base +: NIBBLE_W] <= slice_s;
                    carry_r               <= slice_cout;
                    idx                   <= idx + 1'b1;
                    if (last) begin
                        cout      <= slice_cout;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    idx       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb/tb_cla_seq_adder_ctrl.sv - scoreboard bench for the sequential CLA adder
module tb_cla_seq_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    logic        rand_ready;
    logic        ready_force;
    logic        rnd_bit;

    int checks   = 0;
    int failures = 0;
    int pushes   = 0;
    int pops     = 0;

    logic [16:0] exp_q[$];

    cla_seq_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    assign out_ready = rand_ready ? rnd_bit : ready_force;

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        if (s)
            return {(x >= y), 16'(x - y)};
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts, output int waits);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(ta, tb_v, tc, ts));
                pushes++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                break;
            end
            if (waits >= 200) begin
                checks++; failures++;
                $display("FAIL send_timeout actual=%0d expected=<200", waits);
                in_valid = 1'b0;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL idle_timeout actual=busy expected=idle");
    endtask

    // Monitor: a transfer completes on the edge after a negedge showing valid & ready.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result actual=%0h expected=none", {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    check("result", {15'd0, cout, sum}, {15'd0, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [16:0] bp;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        rand_ready = 1'b0; ready_force = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and busy for the first op, accepted on the first edge after reset.
        ready_force = 1'b1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, w);
        check("first_accept_waits", w, 0);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("lat_out_valid", out_valid, (k == 4) ? 1 : 0);
            check("lat_busy", busy, 1);
            check("lat_in_ready", in_ready, 0);
            if (k < 4) @(posedge clk);
        end
        @(posedge clk);
        #1;
        wait_idle();

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, w);
        send(16'h0FFF, 16'h0000, 1'b1, 1'b0, w);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, w);
        send(16'h0007, 16'h0005, 1'b1, 1'b1, w);
        wait_idle();

        // Back-pressure: result held, new request not taken while DONE.
        ready_force = 1'b0;
        bp = model(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, w);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("bp_reached_done", out_valid, 1);
        @(posedge clk);
        #1;
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_sum", sum, bp[15:0]);
            check("bp_cout", cout, bp[16]);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        ready_force = 1'b1;
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0, w);
        check("bp_accept_waits", w, 1);
        wait_idle();

        // Reset during RUN aborts the operation immediately.
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        pushes -= exp_q.size();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, w);
        check("post_reset_accept_waits", w, 0);
        wait_idle();

        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), w);
        for (int i = 0; i < 500 && (exp_q.size() != 0 || out_valid); i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("transfer_count", pops, pushes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by reusing one 4-bit carry-look-ahead slice over WIDTH/4 cycles, least significant nibble first.
- Sits between an upstream requester and a downstream consumer, with valid/ready handshakes on both sides.
- Trades latency for area: one CLA slice instead of a full-width adder.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived constant; number of slice iterations; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request carries a valid operation
- in_ready  output  1  block can accept a request
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a+~b+1 (a-b)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB; for subtract, 1 means no borrow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, idx=0, carry register=0.
  - sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
- States:
  - IDLE: in_ready=1.
    - On in_valid&in_ready at edge T: capture a, b (b inverted if sub=1) and initial carry (sub ? 1 : cin); idx<=0; state<=RUN.
    - sum is cleared to 0 on capture.
  - RUN: in_ready=0, busy=1. Each edge:
    - slice adds nibble idx of A and B with the carry register.
    - result nibble is written to sum[4*idx+3:4*idx]; carry register <= slice cout; idx<=idx+1.
    - On the edge where idx==NIBBLES-1: cout<=slice cout, out_valid<=1, state<=DONE.
  - DONE: out_valid=1, in_ready=0.
    - sum and cout are held stable while out_ready=0.
    - On out_valid&out_ready: out_valid<=0, state<=IDLE, idx<=0.
    - sum and cout keep their values in IDLE until the next capture.
- Latency:
  - Request accepted at edge T; out_valid high after edge T+NIBBLES (4 cycles for WIDTH=16).
  - The earliest next acceptance is the edge after the output handshake.
- Arithmetic:
  - Modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
  - No overflow flag.
- Boundary conditions:
  - in_valid while in_ready=0: ignored, no state change. Requesters must hold their request until accepted.
  - Inputs a/b/cin/sub changing after capture have no effect on the operation in flight.
  - out_ready high in IDLE or RUN: no effect.
  - out_ready high on the same edge out_valid rises: no transfer that edge; the handshake is evaluated from the next edge.
  - WIDTH=4: RUN lasts exactly one edge.
  - Reset asserted mid-RUN or in DONE: operation aborted, result discarded, all outputs return to reset values immediately.
  - After rst_n deasserts, the first acceptance is possible on the next edge.
- in_ready and busy are decoded combinationally from state; all other outputs are registered.

Decomposition:
- Shared package cla_pkg:
  - NIBBLE_W=4.
  - state enum {IDLE, RUN, DONE}.
  - Helper function for the nibble index width, clog2(NIBBLES), minimum 1.
- One sub-module: cla_nibble.
  - Combinational 4-bit carry-look-ahead slice: a[3:0], b[3:0], cin -> s[3:0], cout.
  - Generate/propagate equations flattened.
  - Verified standalone by exhaustive 512-vector sweep.

Test Plan (WIDTH=16):
- 0x1234 + 0x4321, cin=0, sub=0 -> after 4 RUN edges out_valid=1, sum=0x5555, cout=0; busy high throughout.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles); 0x0FFF + 0x0000, cin=1 -> sum=0x1000, cout=0.
- sub=1: 0x0005 - 0x0007 -> sum=0xFFFE, cout=0; 0x0007 - 0x0005 -> sum=0x0002, cout=1; cin=1 ignored in both.
- Back-pressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> sum and cout stable, in_ready=0, new request not captured. Raise out_ready -> IDLE next edge, then request accepted.
- rst_n pulsed low on 2nd RUN edge of 0xAAAA + 0x5555 -> out_valid=0, sum=0, cout=0, in_ready=1 immediately. Next op 0x0001 + 0x0001 -> sum=0x0002.
- Back-to-back: 20 random ops with random out_ready stalls -> every result matches a+b+cin (or a-b) mod 2^16; no lost or duplicated transfers.
